// File: rtl/sw_pkg.sv
// Shared types and defaults for the board slide-switch debounce port.
package sw_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam int SW_WIDTH        = 8;
  localparam int SW_STABLE_TICKS = 20;
  localparam int SW_CNT_W        = 8;

endpackage

// File: rtl/switch_debounce_port_if.sv
// Switch-side and CPU-side signals of the debounce port.
interface switch_debounce_port_if
  import sw_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);
  logic [WIDTH-1:0] SwIn;
  logic             Ack;
  logic [WIDTH-1:0] SwOut;
  logic             NewData;
  logic [WIDTH-1:0] RiseBits;

  modport master (
    output SwIn,
    output Ack,
    input  SwOut,
    input  NewData,
    input  RiseBits
  );

  modport slave (
    input  SwIn,
    input  Ack,
    output SwOut,
    output NewData,
    output RiseBits
  );
endinterface

// File: rtl/sync_2ff.sv
// Vector two-flop synchronizer; both stages clear on synchronous reset.
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end
endmodule

// File: rtl/switch_debounce_port.sv
// Synchronizes and debounces the slide switches, holding a clean byte plus a
// new-data flag until acknowledged. Define SW_STICKY_RISE_EN for sticky RiseBits.
module switch_debounce_port
  import sw_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int STABLE_TICKS = SW_STABLE_TICKS,
  parameter int CNT_W        = SW_CNT_W
) (
  input  logic                  Clk100MHz,
  input  logic                  Clr,
  input  logic                  SmpEn,
  switch_debounce_port_if.slave sw
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] sw_out;
  logic             new_data;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic             commit;
  logic             commit_chg;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk (Clk100MHz),
    .rst (Clr),
    .d   (sw.SwIn),
    .q   (sync)
  );

  // A commit is the last of STABLE_TICKS matching samples after entry.
  assign commit     = SmpEn && (state == ST_SETTLE) && (sync == cand) && (cnt >= LAST);
  assign commit_chg = commit && (cand != sw_out);

  always_ff @(posedge Clk100MHz) begin
    if (Clr) begin
      cand     <= '0;
      cnt      <= '0;
      state    <= ST_STABLE;
      sw_out   <= '0;
      new_data <= 1'b0;
    end else begin
      if (SmpEn) begin
        case (state)
          ST_STABLE: begin
            if (sync != sw_out) begin
              cand  <= sync;
              cnt   <= '0;
              state <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (sync != cand) begin
              cand <= sync;
              cnt  <= '0;
            end else if (cnt < LAST) begin
              cnt <= cnt + CNT_W'(1);
            end else begin
              state <= ST_STABLE;
              if (cand != sw_out) sw_out <= cand;
            end
          end
          default: state <= ST_STABLE;
        endcase
      end
      // Fresh data outranks a coincident acknowledge.
      if (commit_chg)  new_data <= 1'b1;
      else if (sw.Ack) new_data <= 1'b0;
    end
  end

  assign sw.SwOut   = sw_out;
  assign sw.NewData = new_data;

`ifdef SW_STICKY_RISE_EN
  logic [WIDTH-1:0] rise_bits;

  always_ff @(posedge Clk100MHz) begin
    if (Clr) begin
      rise_bits <= '0;
    end else if (commit_chg) begin
      rise_bits <= (sw.Ack ? '0 : rise_bits) | (cand & ~sw_out);
    end else if (sw.Ack) begin
      rise_bits <= '0;
    end
  end

  assign sw.RiseBits = rise_bits;
`else
  assign sw.RiseBits = '0;
`endif

endmodule

// File: tb/tb_switch_debounce_port.sv
// Randomized and directed bench for switch_debounce_port with a per-clock scoreboard.
module tb_switch_debounce_port;
  localparam int W     = 8;
  localparam int TICKS = 4;

  typedef struct packed {
    logic [W-1:0] sw_out;
    logic         new_data;
    logic [W-1:0] rise;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic smp_en = 1'b0;
  int   smp_mode = 0;   // 0: one strobe every 10 clocks, 1: tied high
  int   smp_div = 0;

  switch_debounce_port_if #(.WIDTH(W)) bus ();

  switch_debounce_port #(
    .WIDTH        (W),
    .STABLE_TICKS (TICKS),
    .CNT_W        (8)
  ) dut (
    .Clk100MHz (clk),
    .Clr       (clr),
    .SmpEn     (smp_en),
    .sw        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (smp_mode == 1) begin
      smp_en = 1'b1;
    end else begin
      smp_div = (smp_div == 9) ? 0 : smp_div + 1;
      smp_en  = (smp_div == 0);
    end
  end

  // Reference: a value seen on TICKS+1 consecutive samples becomes the output.
  exp_t         exp_q[$];
  logic [W-1:0] m_d1 = '0, m_d2 = '0, m_last = '0, m_out = '0, m_rise = '0;
  logic         m_nd = 1'b0;
  int           m_run = 0;

  always @(posedge clk) begin
    logic [W-1:0] seen;
    logic         chg;
    exp_t         e;
    if (clr) begin
      m_d1 = '0; m_d2 = '0; m_last = '0; m_out = '0; m_rise = '0;
      m_nd = 1'b0; m_run = 0;
    end else begin
      seen = m_d2;
      chg  = 1'b0;
      if (smp_en) begin
        if (m_run > 0 && seen == m_last) begin
          if (m_run <= TICKS) m_run++;
        end else begin
          m_last = seen;
          m_run  = 1;
        end
        chg = (m_run == TICKS + 1) && (m_last != m_out);
      end
      if (chg) begin
`ifdef SW_STICKY_RISE_EN
        m_rise = (bus.Ack ? '0 : m_rise) | (m_last & ~m_out);
`endif
        m_out = m_last;
        m_nd  = 1'b1;
      end else if (bus.Ack) begin
        m_nd   = 1'b0;
        m_rise = '0;
      end
      m_d2 = m_d1;
      m_d1 = bus.SwIn;
    end
    e.sw_out   = m_out;
    e.new_data = m_nd;
    e.rise     = m_rise;
    exp_q.push_back(e);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("SwOut", bus.SwOut, e.sw_out);
      check("NewData", {7'd0, bus.NewData}, {7'd0, e.new_data});
      check("RiseBits", bus.RiseBits, e.rise);
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!smp_en) @(posedge clk);
    end
    #2;
  endtask

  task automatic ack_pulse();
    bus.Ack = 1'b1;
    clocks(1);
    bus.Ack = 1'b0;
  endtask

  initial begin
    bus.SwIn = 8'hFF;
    bus.Ack  = 1'b0;
    clocks(3);
    clr = 1'b0;
    samples(8);
    ack_pulse();
    bus.SwIn = 8'h00;
    samples(8);
    ack_pulse();
    bus.SwIn = 8'hA5;
    samples(8);
    ack_pulse();
    bus.SwIn = 8'h00;
    samples(8);
    ack_pulse();
    // Bounce on alternate samples, then settle high.
    for (int i = 0; i < 6; i++) begin
      bus.SwIn = (i % 2 == 0) ? 8'h01 : 8'h00;
      samples(1);
    end
    bus.SwIn = 8'h01;
    samples(8);
    ack_pulse();
    bus.SwIn = 8'h00;
    samples(8);
    ack_pulse();
    bus.SwIn = 8'h10;
    samples(2);
    bus.SwIn = 8'h00;
    samples(8);
    // Ack held across a commit forces the coincident case.
    bus.SwIn = 8'h3C;
    bus.Ack  = 1'b1;
    samples(8);
    bus.Ack  = 1'b0;
    clocks(2);
    ack_pulse();
    bus.SwIn = 8'h00;
    samples(8);
    ack_pulse();
    foreach (bus.SwIn[k]) begin end
    bus.SwIn = 8'h03; samples(7);
    bus.SwIn = 8'h01; samples(7);
    bus.SwIn = 8'h05; samples(7);
    ack_pulse();
    samples(2);
    // Random phase: holds, single-bit bounces, sub-strobe glitches, acks, resets.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    bus.SwIn = W'($urandom);
        2, 3:    bus.SwIn = bus.SwIn ^ (8'h01 << $urandom_range(0, 7));
        4: begin
          bus.SwIn = ~bus.SwIn;
          clocks(2);
          bus.SwIn = ~bus.SwIn;
        end
        default: ;
      endcase
      bus.Ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) clr = 1'b1;
      clocks($urandom_range(1, 12));
      bus.Ack = 1'b0;
      clr     = 1'b0;
      if (i == 250) smp_mode = 1;
      if (i == 330) smp_mode = 0;
    end
    bus.Ack = 1'b0;
    samples(8);
    clocks(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
